// File: rtl/dec24_seq.sv
// dec24_seq: sequential 2-to-4 decoder with an input FIFO.
// Codes arrive on {i1,i0} through a valid/ready handshake and are queued.
// Each queued code is replayed as a one-hot pulse on o0..o3, held for HOLD cycles.
// Ports:
//   clk, rst        : rising-edge clock, async active-high reset
//   in_valid/ready  : push handshake; in_ready = !full
//   i0, i1          : code LSB / MSB
//   o0..o3          : registered one-hot outputs (polarity set by ACTIVE_LOW)
//   busy            : registered, high while a pulse is driven
//   count           : FIFO occupancy
module dec24_seq #(
  parameter int DEPTH      = 4,
  parameter int HOLD       = 3,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       i0,
  input  logic                       i1,
  output logic                       o0,
  output logic                       o1,
  output logic                       o2,
  output logic                       o3,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD - 1);
  localparam logic [3:0]    POL     = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  typedef enum logic {
    IDLE,
    DRIVE
  } state_e;

  state_e          state_q;
  logic [1:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [HW-1:0]   hold_q;
  logic [3:0]      oh_q;
  logic            busy_q;
  logic            push;
  logic            pop;
  logic [3:0]      head_oh;

  // Full is judged on the registered count only, so a same-edge pop
  // never re-opens the input.
  assign in_ready = (count_q != FULL_C);
  assign push     = in_valid && in_ready;
  assign head_oh  = 4'b0001 << mem_q[rd_ptr_q];

  // Pop whenever a code is waiting and the output slot is free:
  // either idle, or the current pulse is on its last cycle.
  always_comb begin
    pop = 1'b0;
    if (count_q != '0) begin
      pop = (state_q == IDLE) || (hold_q == '0);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i1, i0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      oh_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= DRIVE;
            hold_q  <= HOLD_M1;
            oh_q    <= head_oh;
            busy_q  <= 1'b1;
          end
        end
        DRIVE: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
          end else if (pop) begin
            // zero-gap handoff to the next queued code
            hold_q <= HOLD_M1;
            oh_q   <= head_oh;
          end else begin
            state_q <= IDLE;
            oh_q    <= '0;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign {o3, o2, o1, o0} = oh_q ^ POL;
  assign busy             = busy_q;
  assign count            = count_q;

endmodule

// File: tb/tb_dec24_seq.sv
// tb_dec24_seq: bench for dec24_seq.
// Two instances (HOLD=3 active-high, HOLD=1 active-low) checked every cycle.
module tb_dec24_seq;

  localparam int DEPTH = 4;
  localparam int NMAX  = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      inv;
  logic [1:0]      rdy;
  logic [1:0][1:0] cin;
  logic [1:0][3:0] ov;
  logic [1:0]      bsy;
  logic [1:0][2:0] cnt;

  always #5 clk = ~clk;

  dec24_seq #(.DEPTH(DEPTH), .HOLD(3), .ACTIVE_LOW(0)) u_d0 (
    .clk(clk), .rst(rst),
    .in_valid(inv[0]), .in_ready(rdy[0]),
    .i0(cin[0][0]), .i1(cin[0][1]),
    .o0(ov[0][0]), .o1(ov[0][1]), .o2(ov[0][2]), .o3(ov[0][3]),
    .busy(bsy[0]), .count(cnt[0])
  );

  dec24_seq #(.DEPTH(DEPTH), .HOLD(1), .ACTIVE_LOW(1)) u_d1 (
    .clk(clk), .rst(rst),
    .in_valid(inv[1]), .in_ready(rdy[1]),
    .i0(cin[1][0]), .i1(cin[1][1]),
    .o0(ov[1][0]), .o1(ov[1][1]), .o2(ov[1][2]), .o3(ov[1][3]),
    .busy(bsy[1]), .count(cnt[1])
  );

  int tests = 0;
  int fails = 0;
  int e = 0;
  int dens = 100;

  // Reference: for each accepted code, its accept edge and its start edge.
  // A code starts one edge after acceptance, or when the previous pulse ends.
  int ac [2][NMAX];
  int st [2][NMAX];
  int cd [2][NMAX];
  int n  [2];

  // Source-side pending codes (circular) and the one currently offered.
  int pc [2][256];
  int ph [2];
  int pt [2];
  logic [1:0] vld;
  int cur [2];

  function automatic int hd(int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic int m_cnt(int d);
    int c = 0;
    for (int k = 0; k < n[d]; k++) begin
      if (ac[d][k] <= e) c++;
      if (st[d][k] <= e) c--;
    end
    return c;
  endfunction

  function automatic int m_act(int d);
    for (int k = 0; k < n[d]; k++) begin
      if (st[d][k] <= e && e < st[d][k] + hd(d)) return cd[d][k];
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_o(int d);
    logic [3:0] v = 4'h0;
    int a = m_act(d);
    if (a >= 0) v[a] = 1'b1;
    if (d == 1) v = ~v;
    return v;
  endfunction

  task automatic enq(int d, int c);
    pc[d][pt[d] % 256] = c;
    pt[d]++;
  endtask

  task automatic enq_both(int c);
    enq(0, c);
    enq(1, c);
  endtask

  task automatic check_all();
    logic [3:0] eo;
    logic       eb;
    logic [2:0] ec;
    logic       er;
    for (int d = 0; d < 2; d++) begin
      eo = m_o(d);
      eb = (m_act(d) >= 0);
      ec = 3'(m_cnt(d));
      er = (m_cnt(d) < DEPTH);
      tests++;
      assert (ov[d] === eo) else begin
        fails++;
        $error("FAIL out%0d e=%0d got %b exp %b", d, e, ov[d], eo);
      end
      tests++;
      assert (bsy[d] === eb) else begin
        fails++;
        $error("FAIL busy%0d e=%0d got %b exp %b", d, e, bsy[d], eb);
      end
      tests++;
      assert (cnt[d] === ec) else begin
        fails++;
        $error("FAIL count%0d e=%0d got %0d exp %0d", d, e, cnt[d], ec);
      end
      tests++;
      assert (rdy[d] === er) else begin
        fails++;
        $error("FAIL ready%0d e=%0d got %b exp %b", d, e, rdy[d], er);
      end
    end
  endtask

  task automatic step();
    logic [1:0] acc;
    for (int d = 0; d < 2; d++) begin
      acc[d] = !rst && vld[d] && (m_cnt(d) < DEPTH);
    end
    @(posedge clk);
    e++;
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin
        int k = n[d];
        ac[d][k] = e;
        st[d][k] = e + 1;
        if (k > 0 && st[d][k-1] + hd(d) > st[d][k]) begin
          st[d][k] = st[d][k-1] + hd(d);
        end
        cd[d][k] = cur[d];
        n[d]++;
        vld[d] = 1'b0;
      end
    end
    #1;
    check_all();
    for (int d = 0; d < 2; d++) begin
      if (!vld[d] && !rst && ph[d] != pt[d] &&
          $urandom_range(99) < 32'(dens)) begin
        cur[d] = pc[d][ph[d] % 256];
        ph[d]++;
        vld[d] = 1'b1;
      end
      inv[d] = vld[d];
      cin[d] = vld[d] ? 2'(cur[d]) : 2'($urandom_range(3));
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      n[d]   = 0;
      ph[d]  = 0;
      pt[d]  = 0;
      vld[d] = 1'b0;
      inv[d] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    cin = '0;
    clear_model();
    #1;
    check_all();
    repeat (2) step();
    rst = 1'b0;
    step();

    // single code 2
    enq_both(2);
    repeat (8) step();

    // back-to-back 0,1,2,3
    enq_both(0); enq_both(1); enq_both(2); enq_both(3);
    repeat (16) step();

    // backpressure: six codes with valid held high
    enq_both(3); enq_both(2); enq_both(1);
    enq_both(0); enq_both(3); enq_both(2);
    repeat (26) step();

    // streaming 0,3,0,3
    enq_both(0); enq_both(3); enq_both(0); enq_both(3);
    repeat (16) step();

    // randomized traffic
    repeat (40) begin
      dens = 20 + 32'($urandom_range(80));
      for (int d = 0; d < 2; d++) begin
        while (pt[d] - ph[d] < 8) enq(d, 32'($urandom_range(3)));
      end
      repeat (20) step();
    end
    dens = 100;
    repeat (40) step();

    // async reset in the middle of a pulse, between clock edges
    clear_model();
    repeat (8) step();
    enq_both(1); enq_both(2); enq_both(3); enq_both(0); enq_both(1);
    repeat (5) step();
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    check_all();
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();
    enq_both(1);
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
